fifo_same_clock_fill: RTL and testbench

FIFO_SAME_CLOCK_FILL -- requirements
Module: fifo_same_clock_fill

---
 rtl/fifo_same_clock_fill.sv | 100 ++++++++++
 tb/tb_fifo_same_clock_fill.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fifo_same_clock_fill.sv
// Single-clock FIFO with first-word-fall-through output, exact fill count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module fifo_same_clock_fill #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_DEPTH:0]   af_level,
    input  logic [DATA_DEPTH:0]   ae_level,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  nempty,
    output logic                  full,
    output logic [DATA_DEPTH:0]   fill,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  half_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int CAP = 1 << DATA_DEPTH;
    localparam logic [DATA_DEPTH:0] CAP_L  = (DATA_DEPTH+1)'(CAP);
    localparam logic [DATA_DEPTH:0] HALF_L = (DATA_DEPTH+1)'(CAP / 2);

    logic [DATA_DEPTH:0]   wptr_q, wptr_d;
    logic [DATA_DEPTH:0]   rptr_q, rptr_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] ram [CAP];

    logic wr_en;
    logic rd_en;
    logic ovf_evt;
    logic unf_evt;

    // Status flags derived from the registered pointers and live thresholds.
    always_comb begin
        fill         = wptr_q - rptr_q;
        full         = (fill == CAP_L);
        nempty       = (fill != '0);
        almost_full  = (fill >= af_level);
        almost_empty = (fill <= ae_level);
        half_empty   = (fill <= HALF_L);
        data_out     = ram[rptr_q[DATA_DEPTH-1:0]];
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // Accepted operations, error events and next pointer/flag values.
    always_comb begin
        // A simultaneous read frees a slot, so a full FIFO still accepts the write.
        wr_en       = we && (!full || re) && !flush;
        rd_en       = re && nempty && !flush;
        ovf_evt     = we && !re && full;
        unf_evt     = re && !nempty;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            // Flush empties the FIFO but leaves the error history alone.
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + 1'b1;
            if (rd_en) rptr_d = rptr_q + 1'b1;
            // A new event in the clearing cycle takes priority over clr_err.
            overflow_d  = ovf_evt || (overflow_q && !clr_err);
            underflow_d = unf_evt || (underflow_q && !clr_err);
        end
    end

    // Pointer and sticky flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) ram[wptr_q[DATA_DEPTH-1:0]] <= data_in;
    end

endmodule

// File: tb/tb_fifo_same_clock_fill.sv
// Randomized and directed bench for fifo_same_clock_fill against a queue model.
module tb_fifo_same_clock_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, we, re, clr_err;
    logic [15:0] data_in;
    logic [4:0]  af_level, ae_level;
    logic [15:0] data_out;
    logic        nempty, full, almost_full, almost_empty, half_empty;
    logic        overflow, underflow;
    logic [4:0]  fill;

    int n_total = 0;
    int n_fail  = 0;

    logic [15:0] mq[$];
    bit          movf = 1'b0;
    bit          munf = 1'b0;

    fifo_same_clock_fill #(.DATA_WIDTH(16), .DATA_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .we(we), .re(re),
        .data_in(data_in), .af_level(af_level), .ae_level(ae_level),
        .clr_err(clr_err), .data_out(data_out), .nempty(nempty), .full(full),
        .fill(fill), .almost_full(almost_full), .almost_empty(almost_empty),
        .half_empty(half_empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("fill", 32'(fill), 32'(n));
        chk("nempty", 32'(nempty), 32'(n != 0));
        chk("full", 32'(full), 32'(n == 16));
        chk("almost_full", 32'(almost_full), 32'(n >= int'(af_level)));
        chk("almost_empty", 32'(almost_empty), 32'(n <= int'(ae_level)));
        chk("half_empty", 32'(half_empty), 32'(n <= 8));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("underflow", 32'(underflow), 32'(munf));
        if (n != 0) chk("data_out", 32'(data_out), 32'(mq[0]));
    endtask

    // Reference behaviour, evaluated on the pre-edge state.
    task automatic model(input bit w, input bit r, input bit f, input bit c, input logic [15:0] d);
        bit is_full, is_ne;
        if (f) begin
            mq.delete();
            return;
        end
        is_full = (mq.size() == 16);
        is_ne   = (mq.size() != 0);
        movf = (w && !r && is_full) || (movf && !c);
        munf = (r && !is_ne) || (munf && !c);
        if (r && is_ne) void'(mq.pop_front());
        if (w && (!is_full || r)) mq.push_back(d);
    endtask

    task automatic cyc(input bit w, input bit r, input bit f, input bit c, input logic [15:0] d);
        we = w; re = r; flush = f; clr_err = c; data_in = d;
        @(posedge clk);
        model(w, r, f, c, d);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; flush = 0; we = 0; re = 0; clr_err = 0; data_in = '0;
        af_level = 5'd12; ae_level = 5'd3;
        #12;
        check_all();
        chk("reset_ae", 32'(almost_empty), 32'd1);
        chk("reset_he", 32'(half_empty), 32'd1);
        @(negedge clk); rst = 1'b0;

        // Fill to capacity; threshold flags checked at every step.
        for (int i = 1; i <= 16; i++) cyc(1, 0, 0, 0, 16'(i));
        chk("full16", 32'(full), 32'd1);
        cyc(1, 0, 0, 0, 16'hDEAD);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("dout_1", 32'(data_out), 32'h0001);

        // Simultaneous read/write while full.
        cyc(1, 1, 0, 0, 16'h00AA);
        chk("dout_2", 32'(data_out), 32'h0002);
        chk("fill_16", 32'(fill), 32'd16);
        for (int i = 0; i < 15; i++) cyc(0, 1, 0, 0, 16'h0);
        chk("last_aa", 32'(data_out), 32'h00AA);
        cyc(0, 1, 0, 0, 16'h0);
        chk("drained", 32'(nempty), 32'd0);

        // Read from empty together with a write.
        cyc(1, 1, 0, 1, 16'h1234);
        chk("unf_set", 32'(underflow), 32'd1);
        chk("dout_1234", 32'(data_out), 32'h1234);
        cyc(0, 0, 0, 1, 16'h0);
        chk("unf_clr", 32'(underflow), 32'd0);
        cyc(0, 1, 0, 0, 16'h0);

        // Random traffic: wraps pointers many times.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                af_level = 5'($urandom_range(0, 31));
                ae_level = 5'($urandom_range(0, 31));
            end
            cyc(1'($urandom_range(0, 99) < (i % 200 < 100 ? 65 : 35)),
                1'($urandom_range(0, 99) < (i % 200 < 100 ? 35 : 65)),
                1'($urandom_range(0, 99) == 0),
                1'($urandom_range(0, 19) == 0),
                16'($urandom));
        end

        // Flush at fill 9 with a write: write lost, flags kept.
        af_level = 5'd12; ae_level = 5'd3;
        cyc(0, 0, 1, 0, 16'h0);
        cyc(0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0, 16'h0100 + 16'(i));
        chk("fill_9", 32'(fill), 32'd9);
        cyc(1, 0, 1, 0, 16'hBEEF);
        chk("flush_fill", 32'(fill), 32'd0);
        chk("flush_unf", 32'(underflow), 32'd1);

        // Asynchronous reset pulse between edges.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 16'h0200 + 16'(i));
        cyc(1, 1, 0, 0, 16'h0300);
        #2 rst = 1'b1;
        #1;
        mq.delete(); movf = 0; munf = 0;
        check_all();
        chk("rst_fill", 32'(fill), 32'd0);
        #1 rst = 1'b0;
        cyc(1, 0, 0, 0, 16'h4321);
        chk("post_rst", 32'(data_out), 32'h4321);
        cyc(0, 1, 0, 0, 16'h0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
